// File: rtl/mesi_bus_arbiter.sv
// mesi_bus_arbiter: round-robin snoop bus arbiter sequencing MESI bus transactions
module mesi_bus_arbiter #(
  parameter int NREQ = 4,
  parameter int ADDR_W = 32,
  parameter int SNOOP_WIN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [3*NREQ-1:0]        req_op,
  input  logic [ADDR_W*NREQ-1:0]   req_addr,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     shared,
  output logic                     snoop_valid,
  output logic [2:0]               snoop_op,
  output logic [ADDR_W-1:0]        snoop_addr,
  output logic [$clog2(NREQ)-1:0]  snoop_src,
  input  logic [2*NREQ-1:0]        snoop_rsp,
  output logic                     wb_req,
  input  logic                     wb_done,
  output logic                     mem_valid,
  output logic [2:0]               mem_op,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ready,
  output logic                     err_multi_hitm
);
  localparam int IW = $clog2(NREQ);
  localparam logic [2:0] OP_READ = 3'd1, OP_WRITE = 3'd2, OP_INV = 3'd3, OP_RWIM = 3'd4;
  typedef enum logic [2:0] {IDLE, SNOOP, WB, MEM, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, win, pick;
  logic [2:0] op, pick_op;
  logic [ADDR_W-1:0] addr, pick_addr;
  logic [3:0] cnt;
  logic shared_r, any, multi;
  logic [NREQ-1:0] elig, hitm_v, hit_v, sel;
  int d, best;
  // the requester's own snoop slot never counts as a hit
  always_comb begin
    elig = '0;
    hitm_v = '0;
    hit_v = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req[i] && req_op[3*i +: 3] != 3'd0 && req_op[3*i +: 3] <= OP_RWIM;
      hitm_v[i] = IW'(i) != win && snoop_rsp[2*i +: 2] == 2'd2;
      hit_v[i] = IW'(i) != win && snoop_rsp[2*i +: 2] inside {2'd1, 2'd2};
    end
  end
  // distance 0 is the index just after the last completed requester
  always_comb begin
    pick = '0;
    pick_op = '0;
    pick_addr = '0;
    any = 1'b0;
    best = NREQ;
    d = 0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + NREQ - 1 - int'(ptr)) % NREQ;
      if (elig[i] && d < best) begin
        best = d;
        pick = IW'(i);
        pick_op = req_op[3*i +: 3];
        pick_addr = req_addr[ADDR_W*i +: ADDR_W];
        any = 1'b1;
      end
    end
  end
  assign multi = (hitm_v & (hitm_v - NREQ'(1))) != '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !any ? IDLE : pick_op == OP_WRITE ? MEM : SNOOP;
      SNOOP:   state_n = cnt != 4'd0 ? SNOOP : op == OP_INV ? DONE : |hitm_v ? WB : MEM;
      WB:      state_n = wb_done ? MEM : WB;
      MEM:     state_n = mem_ready ? DONE : MEM;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IW'(NREQ - 1);
      win <= '0;
      op <= '0;
      addr <= '0;
      cnt <= '0;
      shared_r <= 1'b0;
      err_multi_hitm <= 1'b0;
    end else begin
      if (state == IDLE && any) begin
        win <= pick;
        op <= pick_op;
        addr <= pick_addr;
        cnt <= 4'(SNOOP_WIN - 1);
        shared_r <= 1'b0;
      end
      if (state == SNOOP && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == SNOOP && cnt == 4'd0) begin
        shared_r <= op == OP_READ && |hit_v;
        err_multi_hitm <= err_multi_hitm | multi;
      end
      if (state == DONE) ptr <= win;
    end
  end
  assign sel = NREQ'(1) << win;
  assign gnt = state != IDLE ? sel : '0;
  assign done = state == DONE ? sel : '0;
  assign shared = state == DONE && shared_r;
  assign snoop_valid = state == SNOOP;
  assign snoop_op = snoop_valid ? op : '0;
  assign snoop_addr = snoop_valid ? addr : '0;
  assign snoop_src = snoop_valid ? win : '0;
  assign wb_req = state == WB;
  assign mem_valid = state == MEM;
  assign mem_op = !mem_valid ? 3'd0 : op == OP_WRITE ? OP_WRITE : OP_READ;
  assign mem_addr = mem_valid ? addr : '0;
endmodule
